// File: rtl/piso_serializer.sv
// Parallel-in serial-out shifter with a valid/ready load handshake.
// Words are sent MSB- or LSB-first, with stall pacing and zero-gap reload on the last bit.
//
// state | meaning
// IDLE  | no word in flight, ready for a load
// SHIFT | presenting sreg's output-end bit, cnt bits remaining
module piso_serializer #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic             shift_en,
  output logic             sout,
  output logic             sout_valid,
  output logic             last,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sreg, sreg_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic             accept;

  assign busy       = (state == SHIFT);
  assign sout_valid = busy;
  assign last       = busy && (cnt == CW'(1));
  assign sout       = busy && (MSB_FIRST ? sreg[WIDTH-1] : sreg[0]);
  assign load_ready = (state == IDLE) || (last && shift_en);
  assign accept     = load_valid && load_ready;

  always_comb begin
    state_nxt = state;
    sreg_nxt  = sreg;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          sreg_nxt  = data_in;
          cnt_nxt   = CW'(WIDTH);
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (shift_en) begin
          if (cnt > CW'(1)) begin
            sreg_nxt = MSB_FIRST ? {sreg[WIDTH-2:0], 1'b0} : {1'b0, sreg[WIDTH-1:1]};
            cnt_nxt  = cnt - CW'(1);
          end else if (accept) begin
            // zero-gap reload: next word's first bit follows the last bit directly
            sreg_nxt = data_in;
            cnt_nxt  = CW'(WIDTH);
          end else begin
            sreg_nxt  = '0;
            cnt_nxt   = '0;
            state_nxt = IDLE;
          end
        end
      end
      default: begin
        sreg_nxt  = '0;
        cnt_nxt   = '0;
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      sreg  <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      sreg  <= sreg_nxt;
      cnt   <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: an MSB-first and an LSB-first instance share stimulus and are
// checked every cycle against a word/bit-index model, plus directed scenario traces.
module tb_piso_serializer;
  localparam int W = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n, load_valid, shift_en;
  logic [W-1:0] data_in;
  logic         rdy_m, sout_m, sv_m, last_m, busy_m;
  logic         rdy_l, sout_l, sv_l, last_l, busy_l;

  piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .load_valid(load_valid),
    .load_ready(rdy_m), .shift_en(shift_en), .sout(sout_m), .sout_valid(sv_m),
    .last(last_m), .busy(busy_m));

  piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .load_valid(load_valid),
    .load_ready(rdy_l), .shift_en(shift_en), .sout(sout_l), .sout_valid(sv_l),
    .last(last_l), .busy(busy_l));

  int n_chk = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // reference model: word in flight and index of the bit being presented (send order)
  bit           m_busy = 1'b0;
  logic [W-1:0] m_word = '0;
  int           m_idx  = 0;
  logic [W-1:0] rx     = '0;

  logic tr_sm[$], tr_sl[$], tr_last[$], tr_rdy[$], tr_rdyl[$], tr_sv[$], tr_busy[$];

  task automatic clear_traces();
    tr_sm.delete(); tr_sl.delete(); tr_last.delete(); tr_rdy.delete();
    tr_rdyl.delete(); tr_sv.delete(); tr_busy.delete();
  endtask

  // one clock cycle: drive, check against model, advance model on the posedge
  task automatic step(input logic r, input logic lv, input logic [W-1:0] d, input logic se);
    logic e_last, e_rdy, e_sm, e_sl;
    rst_n = r; load_valid = lv; data_in = d; shift_en = se;
    #1;
    e_last = m_busy && (m_idx == W-1);
    e_rdy  = !m_busy || (e_last && se);
    e_sm   = m_busy ? m_word[W-1-m_idx] : 1'b0;
    e_sl   = m_busy ? m_word[m_idx] : 1'b0;
    chk("ready_msb", rdy_m, e_rdy);   chk("ready_lsb", rdy_l, e_rdy);
    chk("sout_msb", sout_m, e_sm);    chk("sout_lsb", sout_l, e_sl);
    chk("valid_msb", sv_m, m_busy);   chk("valid_lsb", sv_l, m_busy);
    chk("last_msb", last_m, e_last);  chk("last_lsb", last_l, e_last);
    chk("busy_msb", busy_m, m_busy);  chk("busy_lsb", busy_l, m_busy);
    tr_sm.push_back(sout_m); tr_sl.push_back(sout_l); tr_last.push_back(last_m);
    tr_rdy.push_back(rdy_m); tr_rdyl.push_back(rdy_l); tr_sv.push_back(sv_m);
    tr_busy.push_back(busy_m);
    @(posedge clk);
    if (!r) begin
      m_busy = 1'b0; m_idx = 0; m_word = '0;
    end else begin
      if (sv_m && se) rx = {rx[W-2:0], sout_m};
      if (m_busy && se && e_last) chk("loopback", rx, m_word);
      if (lv && e_rdy) begin
        m_word = d; m_idx = 0; m_busy = 1'b1;
      end else if (m_busy && se) begin
        if (m_idx == W-1) m_busy = 1'b0;
        else m_idx++;
      end
    end
    @(negedge clk);
  endtask

  logic [W-1:0] pat;
  logic [7:0]   pat8;
  logic [6:0]   pat7;

  initial begin
    rst_n = 1'b0; load_valid = 1'b0; shift_en = 1'b0; data_in = '0;
    @(negedge clk);

    // reset then idle
    step(0, 0, '0, 0); step(0, 0, '0, 1);
    clear_traces();
    for (int i = 0; i < 5; i++) step(1, 0, 4'(i), 1'($urandom_range(0, 1)));
    for (int i = 0; i < 5; i++) begin
      chk("idle_ready", tr_rdy[i], 1'b1);
      chk("idle_sout", tr_sm[i], 1'b0);
      chk("idle_busy", tr_busy[i], 1'b0);
    end

    // MSB-first word 1011
    clear_traces();
    step(1, 1, 4'b1011, 1);
    for (int i = 0; i < 5; i++) step(1, 0, '0, 1);
    pat = 4'b1011;
    for (int i = 1; i <= 4; i++) begin
      chk("w1011_sout", tr_sm[i], pat[4-i]);
      chk("w1011_last", tr_last[i], (i == 4));
    end
    chk("w1011_idle", tr_busy[5], 1'b0);
    chk("w1011_rx", rx, 4'b1011);

    // back-to-back A then 5
    clear_traces();
    step(1, 1, 4'hA, 1);
    for (int i = 1; i <= 3; i++) step(1, 0, 4'h5, 1);
    step(1, 1, 4'h5, 1);
    for (int i = 5; i <= 9; i++) step(1, 0, '0, 1);
    pat8 = 8'b1010_0101;
    for (int i = 1; i <= 8; i++) begin
      chk("b2b_sout", tr_sm[i], pat8[8-i]);
      chk("b2b_valid", tr_sv[i], 1'b1);
    end
    for (int i = 0; i < 8; i++) chk("b2b_ready", tr_rdy[i], (i == 0 || i == 4));

    // stall while bit index 1 is presented
    clear_traces();
    step(1, 1, 4'b1100, 1);
    step(1, 0, '0, 1);
    for (int i = 0; i < 3; i++) step(1, 0, '0, 0);
    for (int i = 0; i < 4; i++) step(1, 0, '0, 1);
    pat7 = 7'b1111100;
    for (int i = 1; i <= 7; i++) begin
      chk("stall_sout", tr_sm[i], pat7[7-i]);
      chk("stall_last", tr_last[i], (i == 7));
    end

    // load ignored while busy, LSB-first instance
    clear_traces();
    step(1, 1, 4'b0001, 1);
    step(1, 1, 4'hF, 1);
    for (int i = 0; i < 4; i++) step(1, 0, '0, 1);
    chk("ignore_ready", tr_rdyl[1], 1'b0);
    pat = 4'b0001;
    for (int i = 1; i <= 4; i++) chk("lsb_sout", tr_sl[i], pat[i-1]);
    chk("ignore_idle", tr_busy[5], 1'b0);

    // reset mid-word, then a clean word
    clear_traces();
    step(1, 1, 4'b1111, 1);
    step(1, 0, '0, 1); step(1, 0, '0, 1);
    step(0, 1, 4'b1111, 1);
    step(1, 1, 4'b0110, 1);
    for (int i = 0; i < 5; i++) step(1, 0, '0, 1);
    chk("rst_sout", tr_sm[4], 1'b0);
    chk("rst_valid", tr_sv[4], 1'b0);
    pat = 4'b0110;
    for (int i = 5; i <= 8; i++) chk("after_rst_sout", tr_sm[i], pat[8-i]);

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      clear_traces();
      step(($urandom_range(0, 63) != 0), 1'($urandom_range(0, 1)), 4'($urandom),
           ($urandom_range(0, 3) != 0));
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
